// File: rtl/roll_meter_if.sv
// roll_meter_if: groups the push-button input and the bar/roll outputs of
// roll_meter. The meter side uses the slave modport; whoever drives the button
// and watches the bar (the board glue or a bench) uses the master modport.
// state is a read-only view of the meter FSM, meant for checkers.
interface roll_meter_if #(
    parameter int N = 10
);
    localparam int W = $clog2(N + 1);

    logic         button;
    logic [N-1:0] LED;
    logic         en;
    logic         roll;
    logic [W-1:0] strength;
    logic [1:0]   state;

    modport slave (
        input  button,
        output LED,
        output en,
        output roll,
        output strength,
        output state
    );

    modport master (
        output button,
        input  LED,
        input  en,
        input  roll,
        input  strength,
        input  state
    );
endinterface

// File: rtl/roll_meter.sv
// roll_meter: press-and-hold charge bar. Holding the button fills an N-LED
// thermometer bar one LED per DIV cycles. Releasing the button emits a
// one-cycle roll pulse that carries the captured level. After that the bar
// either drains one LED per DIV cycles (DRAIN=1) or clears at once (DRAIN=0).
// Pressing again during a drain resumes charging from the current level.
module roll_meter #(
    parameter int N     = 10,
    parameter int DIV   = 2500000,
    parameter int DRAIN = 1
) (
    input  logic        clk,
    input  logic        reset,
    roll_meter_if.slave bus
);
    localparam int W  = $clog2(N + 1);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [W-1:0]  LVL_MAX = W'(N);
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CHARGE = 2'd1,
        S_FULL   = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    state_t        state_q, state_n;
    logic [W-1:0]  level_q, level_n;
    logic [PW-1:0] pre_q, pre_n;
    logic [W-1:0]  strength_q, strength_n;
    logic          roll_q, roll_n;
    logic          en_q;
    logic          sync1_q, b_s;
    logic          tick;
    logic [N-1:0]  led_d;

    // The raw button is asynchronous to clk, so it passes through two flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            b_s     <= 1'b0;
        end else begin
            sync1_q <= bus.button;
            b_s     <= sync1_q;
        end
    end

    // The prescaler only runs while the bar is moving, so a tick can only
    // occur in CHARGE or DRAIN.
    assign tick = (pre_q == PRE_MAX);

    // Next-state logic. A release takes priority over a tick. The prescaler
    // restarts from zero whenever the state changes.
    always_comb begin
        state_n    = state_q;
        level_n    = level_q;
        pre_n      = '0;
        roll_n     = 1'b0;
        strength_n = strength_q;
        case (state_q)
            S_IDLE: begin
                level_n = '0;
                if (b_s) state_n = S_CHARGE;
            end
            S_CHARGE: begin
                pre_n = tick ? '0 : pre_q + 1'b1;
                if (!b_s) begin
                    roll_n     = 1'b1;
                    strength_n = level_q;
                    if (DRAIN != 0 && level_q != '0) begin
                        state_n = S_DRAIN;
                    end else begin
                        state_n = S_IDLE;
                        level_n = '0;
                    end
                end else if (tick) begin
                    level_n = level_q + 1'b1;
                    if (level_q == LVL_MAX - 1'b1) state_n = S_FULL;
                end
            end
            S_FULL: begin
                level_n = LVL_MAX;
                if (!b_s) begin
                    roll_n     = 1'b1;
                    strength_n = LVL_MAX;
                    if (DRAIN != 0) begin
                        state_n = S_DRAIN;
                    end else begin
                        state_n = S_IDLE;
                        level_n = '0;
                    end
                end
            end
            S_DRAIN: begin
                pre_n = tick ? '0 : pre_q + 1'b1;
                if (b_s) begin
                    state_n = S_CHARGE;
                end else if (tick) begin
                    level_n = level_q - 1'b1;
                    if (level_q == W'(1)) state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
                level_n = '0;
            end
        endcase
        if (state_n != state_q) pre_n = '0;
    end

    // State, level, prescaler and the registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            level_q    <= '0;
            pre_q      <= '0;
            roll_q     <= 1'b0;
            strength_q <= '0;
            en_q       <= 1'b0;
        end else begin
            state_q    <= state_n;
            level_q    <= level_n;
            pre_q      <= pre_n;
            roll_q     <= roll_n;
            strength_q <= strength_n;
            en_q       <= (state_n == S_FULL);
        end
    end

    // Thermometer decode of the registered level: LED[i] is lit iff i < level.
    always_comb begin
        led_d = '0;
        for (int i = 0; i < N; i++) begin
            led_d[i] = (level_q > W'(i));
        end
    end

    assign bus.LED      = led_d;
    assign bus.en       = en_q;
    assign bus.roll     = roll_q;
    assign bus.strength = strength_q;
    assign bus.state    = state_q;
endmodule
